zigzag_scan_pp: RTL and testbench

Parametrised, double-buffered zigzag scanner for square coefficient blocks. Each N×N block arrives in raster order on a valid/ready input stream. The block emits it on a valid/ready output stream in zigzag order (forward mode) or re-orders zigzag input back to raster order (inverse mode). It sits between the transform/quantiser and the entropy coder, and on the decode path in the reverse direction. It supersedes the fixed 8×8, non-backpressured scanner.

---
 rtl/zigzag_scan_pp.sv | 187 ++++++++++++++++++
 tb/tb_zigzag_scan_pp.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zigzag_scan_pp.sv
`default_nettype none
// ============================================================================
// Module      : zigzag_scan_pp
// Description : Double-buffered N x N zigzag scanner with valid/ready streams.
//               Forward mode emits a raster block in zigzag order; inverse
//               mode restores raster order from a zigzag block.
// Revision    : 1.0 - initial release
// ============================================================================
module zigzag_scan_pp #(
  parameter int DATA_W = 10,
  parameter int N      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_vld,
  output logic              in_rdy,
  input  logic [DATA_W-1:0] din,
  input  logic              mode,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic [DATA_W-1:0] dout,
  output logic              out_sob,
  output logic              out_eob
);

  localparam int L  = N * N;
  localparam int CW = $clog2(N);
  localparam int AW = 2 * CW;
  localparam logic [AW-1:0] LAST  = {AW{1'b1}};
  localparam logic [CW-1:0] C_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] C_ONE = CW'(1);

  // One step of the zigzag walker; dir 0 = up-right, 1 = down-left.
  // Returns {next_dir, next_row, next_col}.
  function automatic logic [AW:0] zz_next(input logic [CW-1:0] r,
                                          input logic [CW-1:0] c,
                                          input logic dir);
    logic [CW-1:0] nr;
    logic [CW-1:0] nc;
    logic          nd;
    nr = r;
    nc = c;
    nd = dir;
    if (!dir) begin
      if (c == C_MAX) begin
        nr = r + C_ONE;
        nd = 1'b1;
      end else if (r == '0) begin
        nc = c + C_ONE;
        nd = 1'b1;
      end else begin
        nr = r - C_ONE;
        nc = c + C_ONE;
      end
    end else begin
      if (r == C_MAX) begin
        nc = c + C_ONE;
        nd = 1'b0;
      end else if (c == '0) begin
        nr = r + C_ONE;
        nd = 1'b0;
      end else begin
        nr = r + C_ONE;
        nc = c - C_ONE;
      end
    end
    return {nd, nr, nc};
  endfunction

  // Two ping-pong banks addressed as {bank, addr}; addr = row*N + col.
  logic [DATA_W-1:0] mem [0:2*L-1];

  logic [1:0]    full;
  logic [1:0]    full_nxt;
  logic [1:0]    bank_mode;

  logic          wr_bank;
  logic [AW-1:0] wr_cnt;
  logic [CW-1:0] wr_r;
  logic [CW-1:0] wr_c;
  logic          wr_dir;

  logic          rd_bank;
  logic [AW-1:0] rd_cnt;
  logic [CW-1:0] rd_r;
  logic [CW-1:0] rd_c;
  logic          rd_dir;
  logic          out_bank;

  logic          wr_fire;
  logic          wr_mode_eff;
  logic [AW-1:0] wr_addr;
  logic [AW:0]   wr_nxt;
  logic          rd_load;
  logic          rd_mode;
  logic [AW-1:0] rd_addr;
  logic [AW:0]   rd_nxt;
  logic          out_fire;

  assign in_rdy   = !rst && !full[wr_bank];
  assign wr_fire  = in_vld && in_rdy;
  // Beat 0 takes the live mode input; later beats use the latched copy.
  assign wr_mode_eff = (wr_cnt == '0) ? mode : bank_mode[wr_bank];
  assign wr_addr  = wr_mode_eff ? {wr_r, wr_c} : wr_cnt;
  assign wr_nxt   = zz_next(wr_r, wr_c, wr_dir);

  assign out_fire = out_vld && out_rdy;
  // Fetch the next beat whenever the output register is empty or being consumed.
  assign rd_load  = full[rd_bank] && (!out_vld || out_rdy);
  assign rd_mode  = bank_mode[rd_bank];
  assign rd_addr  = rd_mode ? rd_cnt : {rd_r, rd_c};
  assign rd_nxt   = zz_next(rd_r, rd_c, rd_dir);

  // Bank occupancy: a bank frees when its last beat is consumed downstream and
  // becomes full when its last beat is written; both may happen on one edge.
  always_comb begin
    full_nxt = full;
    if (out_fire && out_eob) full_nxt[out_bank] = 1'b0;
    if (wr_fire && (wr_cnt == LAST)) full_nxt[wr_bank] = 1'b1;
  end

  // Coefficient storage write port.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[{wr_bank, wr_addr}] <= din;
  end

  // Write/read sequencing, walkers and registered output stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      full      <= '0;
      bank_mode <= '0;
      wr_bank   <= 1'b0;
      wr_cnt    <= '0;
      wr_r      <= '0;
      wr_c      <= '0;
      wr_dir    <= 1'b0;
      rd_bank   <= 1'b0;
      rd_cnt    <= '0;
      rd_r      <= '0;
      rd_c      <= '0;
      rd_dir    <= 1'b0;
      out_bank  <= 1'b0;
      out_vld   <= 1'b0;
      dout      <= '0;
      out_sob   <= 1'b0;
      out_eob   <= 1'b0;
    end else begin
      full <= full_nxt;

      if (wr_fire) begin
        if (wr_cnt == '0) bank_mode[wr_bank] <= mode;
        if (wr_cnt == LAST) begin
          wr_cnt  <= '0;
          wr_r    <= '0;
          wr_c    <= '0;
          wr_dir  <= 1'b0;
          wr_bank <= ~wr_bank;
        end else begin
          wr_cnt <= wr_cnt + AW'(1);
          {wr_dir, wr_r, wr_c} <= wr_nxt;
        end
      end

      if (rd_load) begin
        dout     <= mem[{rd_bank, rd_addr}];
        out_vld  <= 1'b1;
        out_sob  <= (rd_cnt == '0);
        out_eob  <= (rd_cnt == LAST);
        out_bank <= rd_bank;
        if (rd_cnt == LAST) begin
          rd_cnt  <= '0;
          rd_r    <= '0;
          rd_c    <= '0;
          rd_dir  <= 1'b0;
          rd_bank <= ~rd_bank;
        end else begin
          rd_cnt <= rd_cnt + AW'(1);
          {rd_dir, rd_r, rd_c} <= rd_nxt;
        end
      end else if (out_fire) begin
        out_vld <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_zigzag_scan_pp.sv
`default_nettype none
// ============================================================================
// Module      : tb_zigzag_scan_pp
// Description : Self-checking bench for zigzag_scan_pp (N=8 and N=4 instances).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_zigzag_scan_pp;

  typedef struct {
    logic [9:0] d;
    logic       sob;
    logic       eob;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst;
  // N = 8 instance
  logic       in_vld, in_rdy, mode, out_vld, out_rdy, out_sob, out_eob;
  logic [9:0] din, dout;
  // N = 4 instance
  logic       in_vld4, in_rdy4, mode4, out_vld4, out_rdy4, out_sob4, out_eob4;
  logic [9:0] din4, dout4;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int rdy_mode = 0;   // 0: out_rdy high, 1: random 50%, 2: out_rdy low

  beat_t q8[$];
  beat_t q4[$];
  int    zz8[];
  int    inv8[64];
  int    blk[64];
  bit    blk_mode;
  int    zzs4[16] = '{0, 1, 4, 8, 5, 2, 3, 6, 9, 12, 13, 10, 7, 11, 14, 15};

  int    hs4_cnt = 0;
  int    hs4_first = 0;
  int    hs4_last = 0;

  zigzag_scan_pp #(.DATA_W(10), .N(8)) dut8 (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy), .din(din), .mode(mode),
    .out_vld(out_vld), .out_rdy(out_rdy), .dout(dout), .out_sob(out_sob), .out_eob(out_eob)
  );

  zigzag_scan_pp #(.DATA_W(10), .N(4)) dut4 (
    .clk(clk), .rst(rst), .in_vld(in_vld4), .in_rdy(in_rdy4), .din(din4), .mode(mode4),
    .out_vld(out_vld4), .out_rdy(out_rdy4), .dout(dout4), .out_sob(out_sob4), .out_eob(out_eob4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference zigzag order built diagonal by diagonal.
  task automatic gen_zz(input int n, output int t[]);
    int i = 0;
    t = new[n * n];
    for (int s = 0; s < 2 * n - 1; s++) begin
      if (s % 2 == 0) begin
        for (int r = (s < n) ? s : n - 1; r >= 0 && s - r < n; r--) begin
          t[i] = r * n + (s - r);
          i++;
        end
      end else begin
        for (int r = (s < n) ? 0 : s - n + 1; r < n && s - r >= 0; r++) begin
          t[i] = r * n + (s - r);
          i++;
        end
      end
    end
  endtask

  // Expected output of the block currently held in blk/blk_mode.
  task automatic push_block8();
    beat_t b;
    for (int m = 0; m < 64; m++) begin
      b.d   = 10'(blk_mode ? blk[inv8[m]] : blk[zz8[m]]);
      b.sob = (m == 0);
      b.eob = (m == 63);
      q8.push_back(b);
    end
  endtask

  // Offer beats from..to-1 of blk; mode toggles randomly after beat 0.
  task automatic send8(input int from, input int to, input int vld_pct);
    int k = from;
    int guard = 0;
    bit acc;
    while (k < to && guard < 4000) begin
      in_vld = ($urandom_range(99) < vld_pct);
      din    = 10'(blk[k]);
      mode   = (k == 0) ? blk_mode : 1'($urandom_range(1));
      @(negedge clk);
      acc = in_vld && in_rdy;
      @(posedge clk); #1;
      if (acc) begin
        if (k == 63) push_block8();
        k++;
      end
      guard++;
    end
    in_vld = 1'b0;
    check("beats_sent", k, to);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 4000 && q8.size() > 0; i++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    check("drain_left", q8.size(), 0);
    check("idle_vld", out_vld, 0);
  endtask

  // out_rdy driver for the N=8 instance.
  initial begin
    out_rdy = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       out_rdy = 1'b1;
        1:       out_rdy = 1'($urandom_range(1));
        default: out_rdy = 1'b0;
      endcase
    end
  end

  // Output scoreboard and stall-stability monitor for the N=8 instance.
  initial begin
    bit         stall_prev = 0;
    logic [9:0] h_d = '0;
    logic       h_s = 1'b0;
    logic       h_e = 1'b0;
    beat_t      e;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_prev = 0;
      end else begin
        if (stall_prev) begin
          check("hold_vld", out_vld, 1);
          check("hold_dout", dout, h_d);
          check("hold_sob", out_sob, h_s);
          check("hold_eob", out_eob, h_e);
        end
        if (out_vld && out_rdy) begin
          check("sb_nonempty", q8.size() > 0, 1);
          if (q8.size() > 0) begin
            e = q8.pop_front();
            check("dout", dout, e.d);
            check("sob", out_sob, e.sob);
            check("eob", out_eob, e.eob);
          end
        end
        stall_prev = out_vld && !out_rdy;
        h_d = dout;
        h_s = out_sob;
        h_e = out_eob;
      end
    end
  end

  // Output scoreboard for the N=4 instance, recording handshake cycles.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_vld4 && out_rdy4) begin
        check("sb4_nonempty", q4.size() > 0, 1);
        if (q4.size() > 0) begin
          e = q4.pop_front();
          check("dout4", dout4, e.d);
          check("sob4", out_sob4, e.sob);
          check("eob4", out_eob4, e.eob);
        end
        if (hs4_cnt == 0) hs4_first = cyc;
        hs4_last = cyc;
        hs4_cnt++;
      end
    end
  end

  initial begin
    beat_t b;
    gen_zz(8, zz8);
    for (int k = 0; k < 64; k++) inv8[zz8[k]] = k;
    rst = 1'b1;
    in_vld = 1'b0; din = '0; mode = 1'b0;
    in_vld4 = 1'b0; din4 = '0; mode4 = 1'b0; out_rdy4 = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_rdy", in_rdy, 0);
    check("rst_out_vld", out_vld, 0);
    check("rst_dout", dout, 0);
    check("rst_sob", out_sob, 0);
    check("rst_eob", out_eob, 0);
    rst = 1'b0;
    #1;
    check("post_rst_in_rdy", in_rdy, 1);
    check("post_rst_in_rdy4", in_rdy4, 1);

    // Forward N=8 ramp, then latency of the first output beat
    rdy_mode = 0;
    @(posedge clk); #1;
    for (int k = 0; k < 64; k++) blk[k] = k;
    blk_mode = 1'b0;
    send8(0, 64, 100);
    check("lat_bubble", out_vld, 0);
    @(posedge clk); #1;
    check("lat_vld", out_vld, 1);
    check("lat_dout", dout, 0);
    check("lat_sob", out_sob, 1);
    wait_drain();

    // Inverse N=8: zigzag sequence in, raster ramp out
    for (int k = 0; k < 64; k++) blk[k] = zz8[k];
    blk_mode = 1'b1;
    send8(0, 64, 100);
    wait_drain();

    // N=4 back-to-back blocks with alternating mode
    for (int m = 0; m < 32; m++) begin
      b.d   = 10'((m < 16) ? zzs4[m] : m - 16);
      b.sob = (m % 16 == 0);
      b.eob = (m % 16 == 15);
      q4.push_back(b);
    end
    for (int k = 0; k < 32; k++) begin
      in_vld4 = 1'b1;
      din4    = 10'((k < 16) ? k : zzs4[k - 16]);
      mode4   = (k >= 16);
      @(negedge clk);
      check("in_rdy4", in_rdy4, 1);
      @(posedge clk); #1;
    end
    in_vld4 = 1'b0;
    for (int i = 0; i < 200 && hs4_cnt < 32; i++) @(posedge clk);
    #1;
    check("n4_beats", hs4_cnt, 32);
    check("n4_no_bubble", hs4_last - hs4_first, 31);
    check("n4_left", q4.size(), 0);

    // Backpressure: three blocks offered with out_rdy low
    rdy_mode = 2;
    @(posedge clk); #1;
    for (int k = 0; k < 64; k++) blk[k] = k;
    blk_mode = 1'b0;
    send8(0, 64, 100);
    for (int k = 0; k < 64; k++) blk[k] = int'($urandom_range(1023));
    blk_mode = 1'b1;
    send8(0, 64, 100);
    check("bp_in_rdy", in_rdy, 0);
    for (int k = 0; k < 64; k++) blk[k] = int'($urandom_range(1023));
    blk_mode = 1'b0;
    in_vld = 1'b1;
    din    = 10'(blk[0]);
    mode   = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      check("bp_hold_rdy", in_rdy, 0);
      check("bp_hold_vld", out_vld, 1);
      check("bp_hold_dout", dout, 0);
      check("bp_hold_sob", out_sob, 1);
    end
    rdy_mode = 0;
    send8(0, 64, 100);
    wait_drain();

    // Random stalls on both sides, random data and mode
    rdy_mode = 1;
    for (int bk = 0; bk < 20; bk++) begin
      for (int k = 0; k < 64; k++) blk[k] = int'($urandom_range(1023));
      blk_mode = 1'($urandom_range(1));
      send8(0, 64, 50);
    end
    wait_drain();

    // Reset while block 0 drains and block 1 is partially written
    rdy_mode = 2;
    @(posedge clk); #1;
    for (int k = 0; k < 64; k++) blk[k] = k;
    blk_mode = 1'b0;
    send8(0, 64, 100);
    for (int k = 0; k < 64; k++) blk[k] = int'($urandom_range(1023));
    blk_mode = 1'b1;
    send8(0, 20, 100);
    rdy_mode = 0;
    send8(20, 30, 100);
    rst = 1'b1;
    q8.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("mid_rst_vld", out_vld, 0);
    check("mid_rst_rdy", in_rdy, 1);
    for (int k = 0; k < 64; k++) blk[k] = k;
    blk_mode = 1'b0;
    send8(0, 64, 100);
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
